// File: rtl/cdb_arb.sv
// CDB arbiter: per-lane result queues drained round-robin onto NUM_CDB
// registered commit lanes.
module cdb_arb #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_CDB   = 2,
  parameter int DATA_LEN  = 32,
  parameter int ROBID_LEN = 6,
  parameter int QDEPTH    = 2,
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int OCC_W = $clog2(QDEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_v,
  input  logic [NUM_REQ*ROBID_LEN-1:0]   req_robid,
  input  logic [NUM_REQ*DATA_LEN-1:0]    req_data,
  output logic [NUM_REQ-1:0]             req_rdy,
  output logic [NUM_CDB-1:0]             cdb_v,
  output logic [NUM_CDB*ROBID_LEN-1:0]   cdb_robid,
  output logic [NUM_CDB*DATA_LEN-1:0]    cdb_data,
  output logic [NUM_CDB*SRC_W-1:0]       cdb_src,
  output logic [NUM_REQ*OCC_W-1:0]       q_occ
);

  localparam int PTR_W = $clog2(QDEPTH);

  logic [OCC_W-1:0]     occ      [NUM_REQ];
  logic [PTR_W-1:0]     wr_ptr   [NUM_REQ];
  logic [PTR_W-1:0]     rd_ptr   [NUM_REQ];
  logic [ROBID_LEN-1:0] mem_robid[NUM_REQ][QDEPTH];
  logic [DATA_LEN-1:0]  mem_data [NUM_REQ][QDEPTH];

  logic [SRC_W-1:0]     rr_ptr, rr_nxt;
  logic [NUM_REQ-1:0]   push, grant;
  logic [NUM_CDB-1:0]   lane_v_p0;
  logic [SRC_W-1:0]     lane_src_p0  [NUM_CDB];
  logic [ROBID_LEN-1:0] lane_robid_p0[NUM_CDB];
  logic [DATA_LEN-1:0]  lane_data_p0 [NUM_CDB];

  // Readiness looks only at stored occupancy, never at this cycle's pop.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rdy[i] = (occ[i] < OCC_W'(QDEPTH));
      push[i]    = req_v[i] & req_rdy[i];
      q_occ[i*OCC_W +: OCC_W] = occ[i];
    end
  end

  // Stage p0: rotate from rr_ptr and hand the first NUM_CDB non-empty heads to lanes in order.
  always_comb begin
    int cnt;
    int idx;
    cnt       = 0;
    idx       = 0;
    grant     = '0;
    lane_v_p0 = '0;
    rr_nxt    = rr_ptr;
    for (int n = 0; n < NUM_CDB; n++) begin
      lane_src_p0[n]   = '0;
      lane_robid_p0[n] = '0;
      lane_data_p0[n]  = '0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (occ[idx] != '0 && cnt < NUM_CDB) begin
        grant[idx]         = 1'b1;
        lane_v_p0[cnt]     = 1'b1;
        lane_src_p0[cnt]   = SRC_W'(idx);
        lane_robid_p0[cnt] = mem_robid[idx][rd_ptr[idx]];
        lane_data_p0[cnt]  = mem_data[idx][rd_ptr[idx]];
        rr_nxt             = (idx == NUM_REQ - 1) ? '0 : SRC_W'(idx + 1);
        cnt++;
      end
    end
  end

  // Stage p1: queue bookkeeping and registered CDB outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      cdb_v     <= '0;
      cdb_robid <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        occ[i]    <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else if (flush) begin
      rr_ptr    <= '0;
      cdb_v     <= '0;
      cdb_robid <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        occ[i]    <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      rr_ptr <= rr_nxt;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push[i])  wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !grant[i])      occ[i] <= occ[i] + 1'b1;
        else if (!push[i] && grant[i]) occ[i] <= occ[i] - 1'b1;
      end
      for (int n = 0; n < NUM_CDB; n++) begin
        cdb_v[n]                           <= lane_v_p0[n];
        cdb_robid[n*ROBID_LEN +: ROBID_LEN] <= lane_robid_p0[n];
        cdb_data[n*DATA_LEN +: DATA_LEN]    <= lane_data_p0[n];
        cdb_src[n*SRC_W +: SRC_W]           <= lane_src_p0[n];
      end
    end
  end

  // Entry storage carries no reset; occupancy alone says what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        mem_robid[i][wr_ptr[i]] <= req_robid[i*ROBID_LEN +: ROBID_LEN];
        mem_data[i][wr_ptr[i]]  <= req_data[i*DATA_LEN +: DATA_LEN];
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_proto
    a_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(req_v[i] && !req_rdy[i]));
  end

endmodule

// File: tb/tb_cdb_arb.sv
// Directed bench for cdb_arb with a per-requester scoreboard of pushed results.
module tb_cdb_arb;

  localparam int NR = 4;
  localparam int NC = 2;
  localparam int DL = 32;
  localparam int RL = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [NR-1:0]    req_v;
  logic [NR*RL-1:0] req_robid;
  logic [NR*DL-1:0] req_data;
  logic [NR-1:0]    req_rdy;
  logic [NC-1:0]    cdb_v;
  logic [NC*RL-1:0] cdb_robid;
  logic [NC*DL-1:0] cdb_data;
  logic [NC*2-1:0]  cdb_src;
  logic [NR*2-1:0]  q_occ;

  int checks = 0;
  int errors = 0;
  logic [RL+DL-1:0] sb [NR][$];
  int occ_m [NR];
  int grant_cnt [NR];
  logic [3:0] seq [NR];
  logic saw_full;

  cdb_arb dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_v(req_v), .req_robid(req_robid), .req_data(req_data), .req_rdy(req_rdy),
    .cdb_v(cdb_v), .cdb_robid(cdb_robid), .cdb_data(cdb_data), .cdb_src(cdb_src),
    .q_occ(q_occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [RL-1:0] rid, input logic [DL-1:0] d);
    req_v[i] = 1'b1;
    req_robid[i*RL +: RL] = rid;
    req_data[i*DL +: DL]  = d;
  endtask

  task automatic idle();
    req_v = '0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NR; i++) begin
      sb[i].delete();
      occ_m[i] = 0;
    end
  endtask

  // Offer a new result on each masked lane whose queue currently has room.
  task automatic drive_sat(input logic [NR-1:0] mask);
    for (int i = 0; i < NR; i++) begin
      if (mask[i] && req_rdy[i]) begin
        set_req(i, {2'(i), seq[i]}, $urandom);
        seq[i] = seq[i] + 4'd1;
      end else begin
        req_v[i] = 1'b0;
      end
    end
  endtask

  task automatic check_cdb();
    logic [1:0] src;
    logic [RL+DL-1:0] e;
    for (int n = 0; n < NC; n++) begin
      if (cdb_v[n]) begin
        src = cdb_src[n*2 +: 2];
        grant_cnt[src]++;
        occ_m[src]--;
        chk("cdb_no_pending_entry", 64'(sb[src].size() == 0), 64'd0);
        if (sb[src].size() != 0) begin
          e = sb[src].pop_front();
          chk("cdb_robid", 64'(cdb_robid[n*RL +: RL]), 64'(e[RL+DL-1:DL]));
          chk("cdb_data", 64'(cdb_data[n*DL +: DL]), 64'(e[DL-1:0]));
        end
      end else begin
        chk("idle_lane_zero", {cdb_robid[n*RL +: RL], cdb_data[n*DL +: DL], cdb_src[n*2 +: 2]}, 64'd0);
      end
    end
    chk("cdb_v_contiguous", 64'(cdb_v[1] & ~cdb_v[0]), 64'd0);
    for (int i = 0; i < NR; i++) begin
      chk("q_occ", 64'(q_occ[i*2 +: 2]), 64'(occ_m[i]));
      chk("req_rdy", 64'(req_rdy[i]), 64'(occ_m[i] < 2));
    end
  endtask

  // Inputs are driven at the falling edge; outputs are judged at the next falling edge.
  task automatic tick();
    logic [NR-1:0] acc;
    acc = req_v & req_rdy;
    if (!flush) begin
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          sb[i].push_back({req_robid[i*RL +: RL], req_data[i*DL +: DL]});
          occ_m[i]++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (flush) clear_model();
    check_cdb();
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (5) tick();
    for (int i = 0; i < NR; i++) chk("drain_lost_entry", 64'(sb[i].size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    req_v = '0; req_robid = '0; req_data = '0;
    for (int i = 0; i < NR; i++) begin seq[i] = '0; grant_cnt[i] = 0; end
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cdb_v", 64'(cdb_v), 64'd0);
    chk("rst_cdb_fields", {cdb_robid, cdb_data[31:0]}, 64'd0);
    chk("rst_cdb_src", 64'(cdb_src), 64'd0);
    chk("rst_q_occ", 64'(q_occ), 64'd0);
    chk("rst_req_rdy", 64'(req_rdy), 64'hF);
    rst_n = 1'b1;

    // Single push on lane 2
    set_req(2, 6'd5, 32'hDEAD);
    tick();
    chk("s1_not_yet", 64'(cdb_v), 64'd0);
    idle();
    tick();
    chk("s1_v", 64'(cdb_v), 64'b01);
    chk("s1_src", 64'(cdb_src[1:0]), 64'd2);
    chk("s1_robid", 64'(cdb_robid[5:0]), 64'd5);
    chk("s1_data", 64'(cdb_data[31:0]), 64'hDEAD);
    tick();
    chk("s1_done", 64'(cdb_v), 64'd0);
    set_req(0, 6'd10, 32'h10); set_req(3, 6'd13, 32'h13);
    tick(); idle(); tick();
    chk("s1_rr3_v", 64'(cdb_v), 64'b11);
    chk("s1_rr3_src", 64'(cdb_src), {2'd0, 2'd3});

    // Contention from rr_ptr=0
    do_flush();
    set_req(0, 6'd1, 32'hA1); set_req(1, 6'd2, 32'hA2); set_req(3, 6'd3, 32'hA3);
    tick(); idle(); tick();
    chk("s2_v0", 64'(cdb_v), 64'b11);
    chk("s2_src0", 64'(cdb_src), {2'd1, 2'd0});
    chk("s2_robid0", 64'(cdb_robid), {6'd2, 6'd1});
    tick();
    chk("s2_v1", 64'(cdb_v), 64'b01);
    chk("s2_src1", 64'(cdb_src[1:0]), 64'd3);
    chk("s2_robid1", 64'(cdb_robid[5:0]), 64'd3);
    set_req(0, 6'd20, 32'hB0); set_req(3, 6'd23, 32'hB3);
    tick(); idle(); tick();
    chk("s2_rr0_src", 64'(cdb_src), {2'd3, 2'd0});

    // Backpressure with all lanes saturated
    do_flush();
    saw_full = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive_sat(4'hF);
      tick();
      if (q_occ[1:0] == 2'd2) saw_full = 1'b1;
    end
    chk("s3_lane0_filled", 64'(saw_full), 64'd1);
    drain();

    // Fairness: rotation {0,1},{2,3} and 4 grants per lane over 8 cycles
    do_flush();
    for (int i = 0; i < NR; i++) grant_cnt[i] = 0;
    for (int c = 0; c < 9; c++) begin
      drive_sat(4'hF);
      tick();
      if (c >= 1) begin
        chk("s4_v", 64'(cdb_v), 64'b11);
        chk("s4_src0", 64'(cdb_src[1:0]), 64'((2 * (c - 1)) % 4));
        chk("s4_src1", 64'(cdb_src[3:2]), 64'((2 * (c - 1) + 1) % 4));
      end
    end
    for (int i = 0; i < NR; i++) chk("s4_grant_cnt", 64'(grant_cnt[i]), 64'd4);
    drain();

    // Flush with five entries queued and a push in the flush cycle
    do_flush();
    set_req(0, 6'd30, 32'hC0); set_req(1, 6'd31, 32'hC1);
    set_req(2, 6'd32, 32'hC2); set_req(3, 6'd33, 32'hC3);
    tick();
    idle();
    set_req(0, 6'd34, 32'hC4); set_req(1, 6'd35, 32'hC5); set_req(2, 6'd36, 32'hC6);
    tick();
    chk("s5_total_occ", 64'(q_occ[1:0] + q_occ[3:2] + q_occ[5:4] + q_occ[7:6]), 64'd5);
    idle();
    set_req(1, 6'h3F, 32'hBAD0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("s5_cdb_v", 64'(cdb_v), 64'd0);
    chk("s5_q_occ", 64'(q_occ), 64'd0);
    tick(); tick();
    chk("s5_no_flush_push", 64'(cdb_v), 64'd0);
    set_req(0, 6'd40, 32'hD0); set_req(3, 6'd43, 32'hD3);
    tick(); idle(); tick();
    chk("s5_rr0_src", 64'(cdb_src), {2'd3, 2'd0});

    // Asynchronous reset while both lanes are valid
    set_req(0, 6'd50, 32'hE0); set_req(1, 6'd51, 32'hE1);
    tick(); idle(); tick();
    chk("s6_pre_v", 64'(cdb_v), 64'b11);
    set_req(2, 6'd52, 32'hE2); set_req(3, 6'd53, 32'hE3);
    tick();
    idle();
    #3 rst_n = 1'b0;
    #1;
    chk("s6_async_v", 64'(cdb_v), 64'd0);
    chk("s6_async_fields", {cdb_robid, cdb_data[31:0]}, 64'd0);
    chk("s6_async_src", 64'(cdb_src), 64'd0);
    chk("s6_async_occ", 64'(q_occ), 64'd0);
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(1, 6'd60, 32'hF1);
    tick();
    chk("s6_lat0", 64'(cdb_v), 64'd0);
    idle();
    tick();
    chk("s6_v", 64'(cdb_v), 64'b01);
    chk("s6_src", 64'(cdb_src[1:0]), 64'd1);
    tick();
    chk("s6_done", 64'(cdb_v), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arb.md
Name: cdb_arb

Overview:
- Arbiter that shares the CDB_NUM_LANES commit/writeback buses among the CPU_NUM_LANES execution lanes (1-cycle ALU lanes, 2-cycle MUL lanes).
- Each execution lane pushes completed results (robid + data) into a small per-lane queue.
- A round-robin scheduler drains up to NUM_CDB queue heads per cycle onto registered CDB outputs.
- These outputs are the cdb_cmt source consumed by the forwarding mux and the ROB.

Parameters:
- NUM_REQ, 4, number of requesting execution lanes (CPU_NUM_LANES)
- NUM_CDB, 2, number of CDB commit lanes (CDB_NUM_LANES)
- DATA_LEN, 32, result data width
- ROBID_LEN, 6, ROB id width
- QDEPTH, 2, entries per requester queue (power of 2, ≥2)

Ports:
- clk, in, 1, clock
- rst_n, in, 1, asynchronous active-low reset
- flush, in, 1, synchronous pipeline flush (mispredict/exception)
- req_v, in, NUM_REQ, per-lane result valid
- req_robid, in, NUM_REQ×ROBID_LEN, per-lane result ROB id
- req_data, in, NUM_REQ×DATA_LEN, per-lane result data
- req_rdy, out, NUM_REQ, per-lane queue can accept
- cdb_v, out, NUM_CDB, CDB lane valid
- cdb_robid, out, NUM_CDB×ROBID_LEN, CDB lane ROB id
- cdb_data, out, NUM_CDB×DATA_LEN, CDB lane data
- cdb_src, out, NUM_CDB×clog2(NUM_REQ), requester index driving each CDB lane
- q_occ, out, NUM_REQ×clog2(QDEPTH+1), per-lane queue occupancy

Behaviour:

Reset (rst_n=0, async):
- All queues empty and rr_ptr=0.
- cdb_v=0; cdb_robid, cdb_data and cdb_src all 0; q_occ=0.

Enqueue:
- req_rdy[i] = (occ[i] < QDEPTH), combinational from occupancy only. It does not depend on same-cycle grant, so a full queue that is popping still refuses push.
- Push on posedge when req_v[i] & req_rdy[i]. req_v while req_rdy=0 is a producer protocol error: the entry is dropped and an assertion fires.
- Queue is FIFO with wrap-around read/write pointers (mod QDEPTH).

Eligibility and grant:
- A queue is eligible in a cycle iff occ[i]>0 at the start of that cycle. An entry pushed at edge k is first eligible in the cycle after edge k.
- Scan order starts at rr_ptr: rr_ptr, rr_ptr+1, … mod NUM_REQ.
- The first NUM_CDB eligible queues are granted.
- The n-th grant in scan order drives CDB lane n. Lanes beyond the grant count are invalid.
- Each granted queue pops its head at the next edge. At most one pop per queue per cycle.

CDB outputs (registered):
- At the edge ending the grant cycle: cdb_v[n]=1, cdb_robid/cdb_data = head entry, cdb_src[n] = queue index.
- Ungranted lanes: cdb_v=0; robid, data and src driven to 0.
- Latency: push at edge k → cdb_v after edge k+1 (best case, no contention).

rr_ptr update:
- If ≥1 grant: rr_ptr ← (index of last granted queue + 1) mod NUM_REQ.
- If no grant: rr_ptr holds.
- Guarantees that any non-empty queue is granted within ceil(NUM_REQ/NUM_CDB) cycles.

Simultaneous push/pop on the same queue (non-full): occ unchanged, FIFO order preserved.

flush:
- At the edge where flush=1: all queues emptied, rr_ptr←0, all CDB outputs cleared as in reset.
- Pushes and grants in the flush cycle are discarded.
- req_rdy follows the emptied occupancy from the next cycle.

Reset mid-operation: immediate asynchronous clear of all state; no partial CDB output may appear after rst_n deasserts.

Ordering and coverage:
- Per-requester results leave in push order.
- No ordering guarantee across requesters (the ROB reorders by robid).
- No entry is ever duplicated or lost absent flush/reset.

Test Plan:
1. Single push: req_v[2]=1, robid=5, data=0xDEAD at edge 1 → after edge 2: cdb_v=2'b01, cdb_robid[0]=5, cdb_data[0]=0xDEAD, cdb_src[0]=2; after edge 3: cdb_v=0; rr_ptr=3.
2. Contention: rr_ptr=0, push lanes 0,1,3 (robid 1,2,3) at the same edge.
   - Next output: lane0=robid1/src0, lane1=robid2/src1, rr_ptr=2.
   - Following output: lane0=robid3/src3, cdb_v=2'b01, rr_ptr=0.
3. Backpressure: push lane 0 every cycle while lanes 1,2,3 are kept saturated.
   - req_rdy[0] drops to 0 when q_occ[0]=2.
   - No push is accepted while full, even in a pop cycle.
   - All accepted robids appear on CDB in push order; none are duplicated.
4. Fairness: all 4 lanes continuously pushing → over 8 cycles each lane is granted exactly 4 times, the grant pattern rotates {0,1},{2,3},…, and the max wait is ≤2 cycles.
5. Flush: queues hold 5 entries total; assert flush for one cycle together with req_v[1]=1.
   - Next cycle: cdb_v=0, q_occ all 0, rr_ptr=0.
   - The flush-cycle push never appears on the CDB.
6. Async reset: drop rst_n mid-cycle while cdb_v=2'b11 → outputs clear immediately, before the next edge. After release, the first push follows the latency in scenario 1.
